// File: rtl/sub_pipe.sv
// Two-stage pipelined unsigned subtractor (x - y) with borrow and zero flags.
// Sklansky prefix carry network between stages; valid/ready on both sides.
module sub_pipe #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] d,
  output logic         bw,
  output logic         z
);

  localparam int L = $clog2(W);

  typedef struct packed {
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] h;
  } s1_t;

  logic         v1;
  logic         v2;
  logic         adv1;
  logic         adv2;
  s1_t          s1;
  logic [W-1:0] gl [L+1];
  logic [W-1:0] pl [L+1];
  logic [W-1:0] dn;
  logic         bwn;
  logic         zn;

  assign adv2      = ~v2 | out_ready;
  assign adv1      = ~v1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      s1 <= '0;
    end else if (adv1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1.g <= x & ~y;
        s1.p <= x | ~y;
        s1.h <= x ^ ~y;
      end
    end
  end

  // Carry-in of 1 is folded into bit 0 before the prefix tree.
  always_comb begin
    for (int l = 0; l <= L; l++) begin
      gl[l] = '0;
      pl[l] = '0;
    end
    gl[0]    = s1.g;
    gl[0][0] = s1.g[0] | s1.p[0];
    pl[0]    = s1.p;
    for (int l = 0; l < L; l++) begin
      gl[l+1] = gl[l];
      pl[l+1] = pl[l];
      for (int i = 0; i < W; i++) begin
        if (((i >> l) & 1) != 0) begin
          gl[l+1][i] = gl[l][i]
                     | (pl[l][i] & gl[l][((i >> l) << l) - 1]);
          pl[l+1][i] = pl[l][i]
                     & pl[l][((i >> l) << l) - 1];
        end
      end
    end
  end

  assign dn  = s1.h ^ {gl[L][W-2:0], 1'b1};
  assign bwn = ~gl[L][W-1];
  assign zn  = (dn == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      d  <= '0;
      bw <= 1'b0;
      z  <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        d  <= dn;
        bw <= bwn;
        z  <= zn;
      end
    end
  end

endmodule
